seg_disp_sched: RTL and testbench
=================================

Name: seg_disp_sched

Overview:
- Display scheduler that sits in front of the 8-digit multiplexed 7-segment driver and produces its 32-bit BCD word (8 × 4-bit digit codes) and its 1 kHz scan pulse.
- Arbitrates between two sources:
  - a normal value source, with optional leading-zero blanking and blinking;
  - a priority message source (e.g. "Err" codes), shown for a fixed hold time, then returns to the value.
- Digit codes 0-9 are numerals; 4'ha is a dash, 4'hb is blank, 4'hc is "E", 4'hd is "R".

Parameters:
- TICK_DIV, 100000, i_clk cycles per 1 ms tick (100 MHz → 1 kHz).
- MSG_HOLD_MS, 2000, number of ticks a message stays on the display.
- BLINK_HALF_MS, 250, number of ticks per blink half-period.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active-high.
- i_val_bcd  in  32  value digits; [31:28] is digit7 (leftmost), [3:0] is digit0.
- i_val_vld  in  1  single-cycle strobe; captures i_val_bcd.
- i_lzb_en  in  1  leading-zero blanking enable.
- i_blink_en  in  1  blink the value display.
- i_msg_req  in  1  message request (level); served when accepted.
- i_msg_bcd  in  32  message digits, sampled on acceptance.
- o_msg_ack  out  1  one-cycle pulse when a message is accepted.
- o_msg_busy  out  1  high while a message is displayed.
- o_pls_1k  out  1  one-cycle 1 kHz scan pulse to the display driver.
- o_bcd8d  out  32  digit word to the display driver.

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge) sets:
  - o_bcd8d=32'hbbbb_bbbb, o_pls_1k=0, o_msg_ack=0, o_msg_busy=0;
  - state=S_VAL, value register=0, message register=0;
  - tick counter, hold counter and blink counter=0; blink phase=ON.
  - Reset mid-message aborts the message immediately; no ack is generated.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - o_pls_1k=1 for exactly the cycle in which the counter equals TICK_DIV-1.
  - Free-running; not affected by state.
- Value capture: i_val_vld=1 loads the value register on that edge, in either state. A value captured during S_MSG is shown after the message ends.
- State machine (S_VAL, S_MSG):
  - S_VAL, i_msg_req=1: accept the message. Latch i_msg_bcd, pulse o_msg_ack on the next cycle, load hold counter=MSG_HOLD_MS, go to S_MSG.
  - S_MSG, tick with hold counter=1: go to S_VAL.
  - S_MSG, tick with hold counter>1: decrement the hold counter.
  - S_MSG, i_msg_req=1: retrigger. Re-latch the message, ack, reload the hold counter, stay in S_MSG. On the same cycle as an expiring tick, the retrigger wins.
  - A request held high retriggers every cycle. Requesters drop i_msg_req after they see o_msg_ack.
  - o_msg_busy=1 exactly while state=S_MSG (registered with the state).
- Leading-zero blanking (only when i_lzb_en=1):
  - Scan digits 7 down to 1. Each digit equal to 0, with all higher digits also blanked, becomes 4'hb.
  - The first non-zero digit stops blanking.
  - Digit0 is never blanked, so value 0 shows as a single "0".
  - Applies to the value only, never to messages.
- Blink:
  - Applies only in S_VAL with i_blink_en=1.
  - The blink counter counts ticks; at BLINK_HALF_MS ticks it clears and toggles the phase.
  - Phase OFF forces o_bcd8d=32'hbbbb_bbbb.
  - i_blink_en=0 or state=S_MSG clears the blink counter and forces phase ON.
- Output:
  - o_bcd8d is registered. It shows the message register in S_MSG, otherwise the processed value.
  - Latency: one clock from the edge that updates state or the value register to o_bcd8d. Example: strobe at edge N, register loaded at N, o_bcd8d valid after N+1.
- Widths:
  - Hold and blink counters are sized with $clog2(param+1).
  - Tick counter is sized with $clog2(TICK_DIV).
  - No arithmetic is performed on digit data.

Decomposition:
- Package seg_disp_pkg holds:
  - digit code constants DIG_DASH=4'ha, DIG_BLANK=4'hb, DIG_E=4'hc, DIG_R=4'hd, BLANK8=32'hbbbb_bbbb;
  - the state encoding S_VAL/S_MSG.
- Sub-module seg_tick_gen (parameter TICK_DIV; ports i_clk, i_rst, o_tick) generates o_pls_1k. Everything else stays in one module.

Test Plan:
Bench parameters are TICK_DIV=4, MSG_HOLD_MS=3, BLINK_HALF_MS=2.
1. Reset, then idle → o_bcd8d=32'hbbbb_bbbb until first update; o_pls_1k high one cycle in every 4, at counts 3, 7, 11 after reset release.
2. i_val_vld with i_val_bcd=32'h0000_0120, i_lzb_en=1 → o_bcd8d=32'hbbbb_b120 one clock after capture. Same data with i_lzb_en=0 → 32'h0000_0120. Value 0 with blanking on → 32'hbbbb_bbb0.
3. i_msg_req with i_msg_bcd=32'hbbbb_bcdd ("Err") → o_msg_ack one pulse, o_msg_busy=1, message shown for exactly 3 ticks, then the value returns and busy=0.
4. During a message, i_val_vld with 32'h0000_0042, then a second i_msg_req on the cycle of the expiring tick → retrigger wins, hold reloads to 3 ticks. After expiry o_bcd8d=32'h0000_0042 (i_lzb_en=0).
5. i_blink_en=1 in S_VAL → output alternates between value and blank every 2 ticks. A message arrives during an OFF phase → message shown steadily. After it ends, blink restarts in the ON phase.
6. Assert i_rst in the middle of a message → next cycle o_bcd8d=32'hbbbb_bbbb, busy=0, ack=0, and a value captured before reset is lost (register=0).

Source files
------------

// File: rtl/seg_disp_sched_pkg.sv
// Shared digit codes and scheduler state encoding for the 7-segment display path.
package seg_disp_pkg;
  localparam int          NUM_DIG   = 8;
  localparam int          DIG_W     = 4;
  localparam logic [3:0]  DIG_DASH  = 4'ha;
  localparam logic [3:0]  DIG_BLANK = 4'hb;
  localparam logic [3:0]  DIG_E     = 4'hc;
  localparam logic [3:0]  DIG_R     = 4'hd;
  localparam logic [31:0] BLANK8    = 32'hbbbb_bbbb;

  typedef enum logic {S_VAL = 1'b0, S_MSG = 1'b1} state_e;
endpackage

// File: rtl/seg_disp_sched_if.sv
// Value/message request bus and display-driver outputs of the scheduler.
interface seg_disp_sched_if;
  logic [31:0] i_val_bcd;
  logic        i_val_vld;
  logic        i_lzb_en;
  logic        i_blink_en;
  logic        i_msg_req;
  logic [31:0] i_msg_bcd;
  logic        o_msg_ack;
  logic        o_msg_busy;
  logic        o_pls_1k;
  logic [31:0] o_bcd8d;

  modport master (
    output i_val_bcd, i_val_vld, i_lzb_en, i_blink_en, i_msg_req, i_msg_bcd,
    input  o_msg_ack, o_msg_busy, o_pls_1k, o_bcd8d
  );
  modport slave (
    input  i_val_bcd, i_val_vld, i_lzb_en, i_blink_en, i_msg_req, i_msg_bcd,
    output o_msg_ack, o_msg_busy, o_pls_1k, o_bcd8d
  );
endinterface

// File: rtl/seg_disp_sched_tick_gen.sv
// Free-running divider; o_tick is high for the last count of every TICK_DIV-cycle period.
module seg_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);
  localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)              cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else                    cnt_q <= cnt_q + CW'(1);
  end

  assign o_tick = (cnt_q == LAST);
endmodule

// File: rtl/seg_disp_sched.sv
// Display scheduler: value path (leading-zero blanking, blink) arbitrated against
// timed priority messages; drives the 8-digit BCD word and 1 kHz scan pulse.
module seg_disp_sched
  import seg_disp_pkg::*;
#(
  parameter int TICK_DIV      = 100000,
  parameter int MSG_HOLD_MS   = 2000,
  parameter int BLINK_HALF_MS = 250
) (
  input  logic             i_clk,
  input  logic             i_rst,
  seg_disp_sched_if.slave  bus
);
  localparam int            HW        = (MSG_HOLD_MS   > 0) ? $clog2(MSG_HOLD_MS + 1)   : 1;
  localparam int            BW        = (BLINK_HALF_MS > 0) ? $clog2(BLINK_HALF_MS + 1) : 1;
  localparam logic [HW-1:0] HOLD_LD   = HW'(MSG_HOLD_MS);
  localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_HALF_MS);

  state_e       state_q, state_n;
  logic [HW-1:0] hold_q, hold_n;
  logic [31:0]  msg_q, msg_n;
  logic         ack_q, ack_n;
  logic [31:0]  val_q;
  logic         val_ok_q;
  logic [BW-1:0] blink_cnt_q;
  logic         blink_on_q;
  logic [31:0]  bcd_q;
  logic         tick;

  seg_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (tick)
  );

  // A request in either state (re)loads the hold; it beats an expiring tick.
  always_comb begin
    state_n = state_q;
    hold_n  = hold_q;
    msg_n   = msg_q;
    ack_n   = 1'b0;
    if (bus.i_msg_req) begin
      state_n = S_MSG;
      hold_n  = HOLD_LD;
      msg_n   = bus.i_msg_bcd;
      ack_n   = 1'b1;
    end else if (state_q == S_MSG && tick) begin
      if (hold_q > HW'(1)) hold_n  = hold_q - HW'(1);
      else                 state_n = S_VAL;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_VAL;
      hold_q  <= '0;
      msg_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      hold_q  <= hold_n;
      msg_q   <= msg_n;
      ack_q   <= ack_n;
    end
  end

  // val_ok_q keeps the display dark until the first value arrives after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      val_q    <= '0;
      val_ok_q <= 1'b0;
    end else if (bus.i_val_vld) begin
      val_q    <= bus.i_val_bcd;
      val_ok_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || state_q == S_MSG || !bus.i_blink_en) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (tick) begin
      if (blink_cnt_q + BW'(1) == BLINK_TOP) begin
        blink_cnt_q <= '0;
        blink_on_q  <= ~blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  logic [NUM_DIG-1:0][DIG_W-1:0] val_dig, lzb_dig;
  logic [NUM_DIG:1]              blank_run;

  assign val_dig              = val_q;
  assign blank_run[NUM_DIG]   = bus.i_lzb_en;
  assign lzb_dig[0]           = val_dig[0];

  for (genvar d = NUM_DIG - 1; d >= 1; d--) begin : g_lzb
    assign blank_run[d] = blank_run[d+1] && (val_dig[d] == 4'h0);
    assign lzb_dig[d]   = blank_run[d] ? DIG_BLANK : val_dig[d];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                         bcd_q <= BLANK8;
    else if (state_q == S_MSG)         bcd_q <= msg_q;
    else if (!val_ok_q || !blink_on_q) bcd_q <= BLANK8;
    else                               bcd_q <= lzb_dig;
  end

  assign bus.o_bcd8d    = bcd_q;
  assign bus.o_pls_1k   = tick;
  assign bus.o_msg_ack  = ack_q;
  assign bus.o_msg_busy = (state_q == S_MSG);
endmodule

// File: tb/tb_seg_disp_sched.sv
// Randomized + directed bench: a tick/message/blink reference model pushes expected
// outputs each edge; a monitor pops and compares every cycle.
module tb_seg_disp_sched;
  import seg_disp_pkg::*;

  localparam int TD   = 4;
  localparam int HOLD = 3;
  localparam int HALF = 2;

  typedef struct packed {
    logic [31:0] bcd;
    logic        ack;
    logic        busy;
    logic        pls;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_disp_sched_if bus ();

  seg_disp_sched #(
    .TICK_DIV      (TD),
    .MSG_HOLD_MS   (HOLD),
    .BLINK_HALF_MS (HALF)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          m_cnt = 0, m_msg_left = 0, m_blink_ticks = 0;
  logic [31:0] m_val = '0, m_msg = '0;
  bit          m_val_ok = 1'b0;

  localparam logic [31:0] ERR_MSG = {DIG_BLANK, DIG_BLANK, DIG_BLANK, DIG_BLANK,
                                     DIG_BLANK, DIG_E, DIG_R, DIG_R};

  function automatic logic [31:0] m_lzb(input logic [31:0] v, input logic en);
    logic [31:0] r;
    bit lead;
    r    = v;
    lead = en;
    for (int d = 7; d >= 1; d--) begin
      if (lead && v[d*4 +: 4] == 4'h0) r[d*4 +: 4] = DIG_BLANK;
      else lead = 1'b0;
    end
    return r;
  endfunction

  // One edge of the reference model: output from pre-edge state, then advance.
  task automatic model_step();
    exp_t e;
    bit   tick;
    if (rst) begin
      m_cnt = 0; m_msg_left = 0; m_blink_ticks = 0;
      m_val = '0; m_msg = '0; m_val_ok = 1'b0;
      e.bcd = BLANK8; e.ack = 1'b0; e.busy = 1'b0; e.pls = 1'b0;
    end else begin
      tick = ((m_cnt % TD) == TD - 1);
      if (m_msg_left > 0)                                       e.bcd = m_msg;
      else if (!m_val_ok || ((m_blink_ticks / HALF) % 2) == 1) e.bcd = BLANK8;
      else                                                      e.bcd = m_lzb(m_val, bus.i_lzb_en);
      if (m_msg_left == 0 && bus.i_blink_en) begin
        if (tick) m_blink_ticks++;
      end else begin
        m_blink_ticks = 0;
      end
      e.ack = bus.i_msg_req;
      if (bus.i_msg_req) begin
        m_msg      = bus.i_msg_bcd;
        m_msg_left = HOLD;
      end else if (m_msg_left > 0 && tick) begin
        m_msg_left--;
      end
      if (bus.i_val_vld) begin
        m_val    = bus.i_val_bcd;
        m_val_ok = 1'b1;
      end
      m_cnt++;
      e.busy = (m_msg_left > 0);
      e.pls  = ((m_cnt % TD) == TD - 1);
    end
    sb.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_empty t=%0t got bcd=%h", $time, bus.o_bcd8d);
      end else begin
        e = sb.pop_front();
        if (bus.o_bcd8d !== e.bcd || bus.o_msg_ack !== e.ack ||
            bus.o_msg_busy !== e.busy || bus.o_pls_1k !== e.pls) begin
          bad++;
          $display("FAIL out t=%0t got bcd=%h ack=%b busy=%b pls=%b want bcd=%h ack=%b busy=%b pls=%b",
                   $time, bus.o_bcd8d, bus.o_msg_ack, bus.o_msg_busy, bus.o_pls_1k,
                   e.bcd, e.ack, e.busy, e.pls);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_val(input logic [31:0] v);
    bus.i_val_bcd = v; bus.i_val_vld = 1'b1;
    @(negedge clk);
    bus.i_val_vld = 1'b0;
  endtask

  task automatic put_msg(input logic [31:0] v);
    bus.i_msg_bcd = v; bus.i_msg_req = 1'b1;
    @(negedge clk);
    bus.i_msg_req = 1'b0;
  endtask

  task automatic timeout_check(input string name, input int guard);
    total++;
    if (guard >= 100) begin
      bad++;
      $display("FAIL %s wait expired got %0d cycles want <100", name, guard);
    end
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    bus.i_val_bcd = '0; bus.i_val_vld = 1'b0; bus.i_lzb_en = 1'b0;
    bus.i_blink_en = 1'b0; bus.i_msg_req = 1'b0; bus.i_msg_bcd = '0;
    idle(3);
    rst = 1'b0;
    idle(12);

    // value capture with and without leading-zero blanking
    bus.i_lzb_en = 1'b1;
    put_val(32'h0000_0120); idle(3);
    bus.i_lzb_en = 1'b0; idle(2);
    bus.i_lzb_en = 1'b1;
    put_val(32'h0000_0000); idle(3);

    // plain message, then return to value
    put_msg(ERR_MSG); idle(20);

    // value captured mid-message, retrigger on the expiring tick
    bus.i_lzb_en = 1'b0;
    put_msg(ERR_MSG); idle(2);
    put_val(32'h0000_0042);
    guard = 0;
    while (!(m_msg_left == 1 && (m_cnt % TD) == TD - 1) && guard < 100) begin
      @(negedge clk); guard++;
    end
    timeout_check("expire_wait", guard);
    put_msg(32'hbbbb_bcdd); idle(20);

    // blink, message during OFF phase, blink restarts ON
    bus.i_blink_en = 1'b1; idle(12);
    guard = 0;
    while (!(m_msg_left == 0 && ((m_blink_ticks / HALF) % 2) == 1) && guard < 100) begin
      @(negedge clk); guard++;
    end
    timeout_check("blink_off_wait", guard);
    put_msg({DIG_DASH, DIG_DASH, 24'hbbb_cdd}); idle(24);
    bus.i_blink_en = 1'b0; idle(2);

    // reset mid-message drops message and value
    put_msg(ERR_MSG); idle(2);
    put_val(32'h0000_0077); idle(1);
    rst = 1'b1; idle(1);
    rst = 1'b0; idle(6);

    for (int i = 0; i < 600; i++) begin
      bus.i_val_vld = ($urandom_range(0, 7) == 0);
      bus.i_val_bcd = $urandom >> (4 * $urandom_range(0, 8));
      bus.i_msg_req = ($urandom_range(0, 24) == 0);
      bus.i_msg_bcd = ($urandom_range(0, 1) == 0) ? ERR_MSG : $urandom;
      if ($urandom_range(0, 19) == 0) bus.i_lzb_en   = ~bus.i_lzb_en;
      if ($urandom_range(0, 39) == 0) bus.i_blink_en = ~bus.i_blink_en;
      rst = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    bus.i_val_vld = 1'b0; bus.i_msg_req = 1'b0; rst = 1'b0;
    idle(4);
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
